// File: rtl/fm_sb_pkg.sv
// fm_sb_pkg: shared constants and freeze-sequencer state encoding for the FM spy-buffer bank
package fm_sb_pkg;
  localparam int sb_mapped_n = 32;
  localparam int pt_w = 10;
  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_armed  = 2'd1,
    st_post   = 2'd2,
    st_frozen = 2'd3
  } fm_frz_state_t;
endpackage

// File: rtl/fm_sat_counter.sv
// fm_sat_counter: saturating up-counter with synchronous clear
module fm_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/fm_freeze_seq.sv
// fm_freeze_seq: arm/trigger/post-window/freeze sequencer driving the spy-buffer freeze vector
module fm_freeze_seq
  import fm_sb_pkg::*;
#(
  parameter int SB_N  = sb_mapped_n,
  parameter int PT_W  = pt_w,
  parameter int CNT_W = 16
) (
  input  logic             clk_hs,
  input  logic             rst_hs,
  input  logic             arm,
  input  logic             sw_trig,
  input  logic             hw_trig,
  input  logic [SB_N-1:0]  trig_mask,
  input  logic [PT_W-1:0]  post_trig,
  input  logic             rel,
  output logic [SB_N-1:0]  freeze,
  output logic [1:0]       state_o,
  output logic             frozen,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] drop_count
);
  fm_frz_state_t state, nxt;
  logic hw_q, hw_edge, trg, accept, frozen_d;
  logic [SB_N-1:0] mask_q, freeze_d;
  logic [PT_W-1:0] pt_cnt;
  assign trg = sw_trig | hw_edge;
  assign accept = state == st_armed && trg && !rel;
  assign state_o = state;
  always_ff @(posedge clk_hs)
    state <= rst_hs ? st_idle : nxt;
  always_comb begin
    nxt = rel                                 ? st_idle   :
          (state == st_idle  && arm)          ? st_armed  :
          (state == st_armed && trg)          ? st_post   :
          (state == st_post  && pt_cnt == '0) ? st_frozen : state;
  end
  always_comb begin
    freeze_d = (nxt == st_frozen) ? mask_q : '0;
    frozen_d = nxt == st_frozen;
  end
  // hw_q resets high so a level already asserted out of reset is not taken as an edge
  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      hw_q    <= 1'b1;
      hw_edge <= 1'b0;
      mask_q  <= '0;
      pt_cnt  <= '0;
      freeze  <= '0;
      frozen  <= 1'b0;
    end else begin
      hw_q    <= hw_trig;
      hw_edge <= hw_trig & ~hw_q;
      mask_q  <= accept ? trig_mask : mask_q;
      pt_cnt  <= accept                                ? post_trig      :
                 (state == st_post && rel)             ? '0             :
                 (state == st_post && pt_cnt != '0)    ? pt_cnt - PT_W'(1) : pt_cnt;
      freeze  <= freeze_d;
      frozen  <= frozen_d;
    end
  end
  fm_sat_counter #(.W(CNT_W)) u_trig_cnt (
    .clk(clk_hs), .clr(rst_hs), .inc(state == st_armed && trg), .cnt(trig_count)
  );
  fm_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk(clk_hs), .clr(rst_hs), .inc(state != st_armed && trg), .cnt(drop_count)
  );
endmodule

// File: tb/tb_fm_freeze_seq.sv
// tb_fm_freeze_seq: directed stimulus with queued expectations checked by a negedge monitor
module tb_fm_freeze_seq;
  localparam int SB_N = 32;
  localparam int PT_W = 10;
  localparam int CNT_W = 6;
  localparam int EW = 2 + SB_N + 1 + 2 * CNT_W;
  logic clk_hs = 1'b0, rst_hs, arm, sw_trig, hw_trig, rel;
  logic [SB_N-1:0] trig_mask, freeze;
  logic [PT_W-1:0] post_trig;
  logic [1:0] state_o;
  logic frozen;
  logic [CNT_W-1:0] trig_count, drop_count;
  logic [EW-1:0] exp_q[$];
  string name_q[$];
  int checks = 0, errors = 0;

  fm_freeze_seq #(.SB_N(SB_N), .PT_W(PT_W), .CNT_W(CNT_W)) dut (
    .clk_hs(clk_hs), .rst_hs(rst_hs), .arm(arm), .sw_trig(sw_trig), .hw_trig(hw_trig),
    .trig_mask(trig_mask), .post_trig(post_trig), .rel(rel), .freeze(freeze),
    .state_o(state_o), .frozen(frozen), .trig_count(trig_count), .drop_count(drop_count)
  );

  always #5 clk_hs = ~clk_hs;

  always @(negedge clk_hs) begin
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {state_o, freeze, frozen, trig_count, drop_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d frz=%h fr=%b tc=%0d dc=%0d want st=%0d frz=%h fr=%b tc=%0d dc=%0d",
                 n, a[EW-1-:2], a[EW-3-:SB_N], a[2*CNT_W], a[2*CNT_W-1-:CNT_W], a[CNT_W-1:0],
                 e[EW-1-:2], e[EW-3-:SB_N], e[2*CNT_W], e[2*CNT_W-1-:CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: wait expired, CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk_hs);
    #1;
  endtask

  task automatic expect_st(input string n, input logic [1:0] st, input logic [SB_N-1:0] frz,
                           input int tc, input int dc);
    exp_q.push_back({st, frz, st == 2'd3, CNT_W'(tc), CNT_W'(dc)});
    name_q.push_back(n);
  endtask

  initial begin
    rst_hs = 1; arm = 0; sw_trig = 0; hw_trig = 1; rel = 0;
    trig_mask = '0; post_trig = '0;
    cyc(2);
    rst_hs = 0;
    checks++;
    if ({state_o, freeze, frozen, trig_count, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: st=%0d frz=%h fr=%b tc=%0d dc=%0d",
               state_o, freeze, frozen, trig_count, drop_count);
    end
    cyc(3);
    expect_st("reset_hw_high", 0, '0, 0, 0);
    hw_trig = 0;
    arm = 1; cyc(); arm = 0;
    expect_st("armed", 1, '0, 0, 0);
    sw_trig = 1; post_trig = 5; trig_mask = 32'h0000_00F0; cyc();
    sw_trig = 0; post_trig = 0; trig_mask = '1;
    expect_st("accept_sw", 2, '0, 1, 0);
    cyc(5);
    expect_st("post_t5", 2, '0, 1, 0);
    cyc();
    expect_st("frozen_t6", 3, 32'h0000_00F0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      sw_trig = 1; cyc(); sw_trig = 0; cyc();
    end
    expect_st("drop_frozen", 3, 32'h0000_00F0, 1, 2);
    rel = 1; cyc(); rel = 0;
    expect_st("release_frozen", 0, '0, 1, 2);
    sw_trig = 1; cyc(); sw_trig = 0;
    expect_st("drop_idle", 0, '0, 1, 3);
    arm = 1; cyc(); arm = 0;
    post_trig = 0; trig_mask = 32'h0000_000F; hw_trig = 1; cyc();
    expect_st("hw_edge_cycle", 1, '0, 1, 3);
    cyc();
    expect_st("hw_accept", 2, '0, 2, 3);
    cyc();
    expect_st("hw_frozen", 3, 32'h0000_000F, 2, 3);
    hw_trig = 0;
    arm = 1; cyc(); arm = 0;
    expect_st("arm_ignored_frozen", 3, 32'h0000_000F, 2, 3);
    rel = 1; cyc(); rel = 0;
    expect_st("hw_release", 0, '0, 2, 3);
    arm = 1; cyc(); arm = 0;
    post_trig = 10; trig_mask = 32'hFF; sw_trig = 1; cyc(); sw_trig = 0;
    expect_st("accept_pt10", 2, '0, 3, 3);
    cyc();
    sw_trig = 1; cyc(); sw_trig = 0;
    expect_st("drop_post", 2, '0, 3, 4);
    cyc();
    rel = 1; cyc(); rel = 0;
    expect_st("abort_post", 0, '0, 3, 4);
    cyc(12);
    expect_st("no_freeze_after_abort", 0, '0, 3, 4);
    arm = 1; cyc(); arm = 0;
    sw_trig = 1; rel = 1; cyc(); sw_trig = 0; rel = 0;
    expect_st("rel_trig_armed", 0, '0, 4, 4);
    arm = 1; cyc(); arm = 0;
    sw_trig = 1; post_trig = 1; trig_mask = '0; cyc(); sw_trig = 0;
    expect_st("zero_mask_post", 2, '0, 5, 4);
    arm = 1; cyc(); arm = 0;
    expect_st("arm_ignored_post", 2, '0, 5, 4);
    cyc();
    expect_st("zero_mask_frozen", 3, '0, 5, 4);
    rel = 1; cyc(); rel = 0;
    for (int i = 0; i < 58; i++) begin
      arm = 1; cyc(); arm = 0;
      sw_trig = 1; rel = 1; cyc(); sw_trig = 0; rel = 0;
    end
    expect_st("trig_at_max", 0, '0, 63, 4);
    arm = 1; cyc(); arm = 0;
    sw_trig = 1; rel = 1; cyc(); sw_trig = 0; rel = 0;
    expect_st("trig_saturated", 0, '0, 63, 4);
    sw_trig = 1; cyc(70); sw_trig = 0;
    expect_st("drop_saturated", 0, '0, 63, 63);
    arm = 1; cyc(); arm = 0;
    sw_trig = 1; post_trig = 0; trig_mask = 32'hA5A5_0001; cyc(); sw_trig = 0;
    cyc();
    expect_st("frozen_before_rst", 3, 32'hA5A5_0001, 63, 63);
    rst_hs = 1; cyc(); rst_hs = 0;
    expect_st("reset_frozen", 0, '0, 0, 0);
    cyc(3);
    expect_st("idle_after_rst", 0, '0, 0, 0);
    @(negedge clk_hs);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fm_freeze_seq.md
# fm_freeze_seq

Freeze sequencer for the FM spy-buffer bank. It sits between the FM control registers and the spy-buffer datapath, on the `clk_hs` domain, and drives the per-buffer `freeze` vector that the datapath consumes. It arms on a software request and accepts a software or hardware trigger. It then waits a programmable post-trigger window so the buffers capture post-event history, freezes the selected buffers, and holds them frozen until software releases them. Accepted and dropped triggers are counted for monitoring.

## Interface
Parameters:
- `SB_N`, 32: number of mapped spy buffers.
- `PT_W`, 10: post-trigger count width.
- `CNT_W`, 16: width of the monitoring counters.

Ports:
- `clk_hs`  in  1: the block's single clock.
- `rst_hs`  in  1: synchronous, active-high reset.
- `arm`  in  1: single-cycle arm request.
- `sw_trig`  in  1: single-cycle software trigger.
- `hw_trig`  in  1: hardware trigger, level; edge-detected internally.
- `trig_mask`  in  SB_N: buffers to freeze; latched at trigger acceptance.
- `post_trig`  in  PT_W: post-trigger delay in cycles; latched at trigger acceptance.
- `release`  in  1: single-cycle release/abort.
- `freeze`  out  SB_N: per-buffer freeze, registered.
- `state_o`  out  2: current state (IDLE=0, ARMED=1, POST=2, FROZEN=3).
- `frozen`  out  1: high in FROZEN.
- `trig_count`  out  CNT_W: accepted triggers, saturating.
- `drop_count`  out  CNT_W: triggers arriving outside ARMED, saturating.

## Operation
- Trigger event `trg` = `sw_trig` OR a rising edge of `hw_trig`.
  - The edge detector's previous-value register resets to 1, so a level already high at reset is not an edge.
- State machine:
  - IDLE: on `arm` -> ARMED.
  - ARMED: on `trg` -> POST.
    - On the same cycle, latch `trig_mask` into `mask_q` and `post_trig` into the down-counter `pt_cnt`.
    - Increment `trig_count`.
  - POST: decrement `pt_cnt` each cycle. When `pt_cnt`=0 -> FROZEN, and `freeze` <= `mask_q` on that edge.
  - FROZEN: `freeze` held at `mask_q`. On `release` -> IDLE and `freeze` <= 0.
- `release` in ARMED or POST aborts to IDLE. No freeze is issued and `pt_cnt` is cleared.
- `arm` outside IDLE is ignored.
- `trg` in IDLE, POST or FROZEN increments `drop_count`. The state is unchanged.
- Simultaneous events:
  - `release` has priority over `trg` and `arm` in every state.
  - `release` together with `trg` in ARMED: -> IDLE. `trig_count` still increments, because the trigger was seen while ARMED.
- Counters saturate at all-ones and never wrap.
- `trig_mask`=0: the sequence runs normally and FROZEN is reached with `freeze`=0.
- Reset, including mid-sequence: state IDLE, `freeze`=0, `frozen`=0, both counters 0, `mask_q`=0, `pt_cnt`=0.
  - Counters clear only on reset.

## Timing
- `arm` sampled at edge N -> `state_o`=ARMED from cycle N+1.
- `trg` sampled in ARMED at edge T -> `freeze` asserts at edge T+`post_trig`+1.
  - `post_trig`=0 gives one cycle in POST.
  - The maximum delay is 2^PT_W.
- `hw_trig` edge detection adds one cycle: a rise visible at edge T-1 is accepted at edge T.
- `release` sampled at edge R in FROZEN -> `freeze`=0 and `state_o`=IDLE from R+1.
- All outputs are registered, with no combinational input-to-output path.
- Counter increments are visible the cycle after the event.
- `trig_mask` and `post_trig` may change freely except on the acceptance cycle.

## Structure
- The following belong in `fm_sb_pkg`:
  - `fm_frz_state_t` enum.
  - Default `SB_N` tied to `sb_mapped_n`.
  - The `PT_W` constant.
- Sub-module `fm_sat_counter` (parameter width, ports `inc`, `clr`, `cnt`), instantiated twice for `trig_count` and `drop_count`.
- FSM, edge detector and `pt_cnt` stay in the top module.

## Test plan
- Reset, then `arm`, then `sw_trig` with `post_trig`=5 and `trig_mask`=0x0000_00F0.
  - `freeze`=0x0000_00F0 exactly 6 cycles after the trigger.
  - `trig_count`=1.
- `post_trig`=0 with `hw_trig` rising while ARMED: `freeze` high 2 cycles after the rise (edge-detect cycle plus the one-cycle POST state).
- `release` 3 cycles into POST with `post_trig`=10: return to IDLE, `freeze` never asserts, `drop_count`=0.
- `sw_trig` pulsed in IDLE, again in POST, and twice in FROZEN: `drop_count`=4 and the state sequence is unaffected.
- `release` and `sw_trig` in the same ARMED cycle: IDLE, `freeze`=0, `trig_count`=1.
- Force `trig_count` to all-ones with a further accepted trigger: it stays all-ones. Assert `rst_hs` while FROZEN: all outputs 0 on the next cycle.
